// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: issue and writeback signals between decode/writeback and the scoreboard
interface regfile_scoreboard_if;
  logic       iss_valid, iss_ready;
  logic       iss_src0_en, iss_src1_en, iss_dst0_en, iss_dst1_en;
  logic [3:0] iss_src0, iss_src1, iss_dst0, iss_dst1;
  logic [1:0] hazard;
  logic       wb_valid, wb_dst0_en, wb_dst1_en;
  logic [3:0] wb_dst0, wb_dst1;
  modport master (
    output iss_valid, iss_src0_en, iss_src0, iss_src1_en, iss_src1,
           iss_dst0_en, iss_dst0, iss_dst1_en, iss_dst1,
           wb_valid, wb_dst0_en, wb_dst0, wb_dst1_en, wb_dst1,
    input  iss_ready, hazard
  );
  modport slave (
    input  iss_valid, iss_src0_en, iss_src0, iss_src1_en, iss_src1,
           iss_dst0_en, iss_dst0, iss_dst1_en, iss_dst1,
           wb_valid, wb_dst0_en, wb_dst0, wb_dst1_en, wb_dst1,
    output iss_ready, hazard
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register in-flight write counters gating issue against pending writebacks
// Optional SB_WB_BYPASS_EN: same-cycle releases count toward hazard/saturation checks.
module regfile_scoreboard #(
  parameter int NREGS = 16,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  regfile_scoreboard_if.slave  sb,
  output logic [NREGS-1:0]     busy_vec,
  output logic                 underflow_err,
  output logic [31:0]          stall_cycles
);
  localparam int W = CNT_W + 2;
  localparam logic [W-1:0] MAX = W'((1 << CNT_W) - 1);
  logic [CNT_W-1:0] cnt [NREGS];
  logic [CNT_W-1:0] nxt [NREGS];
  logic [W-1:0] req [NREGS], rel [NREGS], avail [NREGS], sum [NREGS];
  logic sat, under, fire;
  always_comb begin
    sat = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      req[r] = W'(sb.iss_dst0_en && sb.iss_dst0 == 4'(r)) + W'(sb.iss_dst1_en && sb.iss_dst1 == 4'(r));
      rel[r] = sb.wb_valid ? W'(sb.wb_dst0_en && sb.wb_dst0 == 4'(r)) + W'(sb.wb_dst1_en && sb.wb_dst1 == 4'(r)) : '0;
`ifdef SB_WB_BYPASS_EN
      avail[r] = W'(cnt[r]) > rel[r] ? W'(cnt[r]) - rel[r] : '0;
`else
      avail[r] = W'(cnt[r]);
`endif
      sat = sat | (avail[r] + req[r] > MAX);
    end
  end
  assign sb.hazard[0] = sb.iss_src0_en && avail[sb.iss_src0] != '0;
  assign sb.hazard[1] = sb.iss_src1_en && avail[sb.iss_src1] != '0;
  assign sb.iss_ready = !sb.hazard[0] && !sb.hazard[1] && !sat;
  assign fire = sb.iss_valid && sb.iss_ready;
  // Over-release clamps at zero; the ready gate keeps every non-clamped result within CNT_W bits.
  always_comb begin
    under = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      sum[r] = W'(cnt[r]) + (fire ? req[r] : '0);
      under = under | (rel[r] > sum[r]);
      nxt[r] = rel[r] > sum[r] ? '0 : CNT_W'(sum[r] - rel[r]);
      busy_vec[r] = cnt[r] != '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      underflow_err <= 1'b0;
      stall_cycles <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= flush ? '0 : nxt[r];
      underflow_err <= underflow_err | (under & ~flush);
      if (sb.iss_valid && !sb.iss_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors with hand-computed expectations for regfile_scoreboard
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset_n, flush;
  logic [15:0] busy_vec;
  logic underflow_err;
  logic [31:0] stall_cycles;
  int checks = 0, errors = 0;
  regfile_scoreboard_if sb ();
  regfile_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .sb(sb),
    .busy_vec(busy_vec), .underflow_err(underflow_err), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
`ifdef SB_WB_BYPASS_EN
  localparam logic [1:0]  HZ_WB = 2'b00;
  localparam logic [31:0] STALL_WB = 32'd3;
`else
  localparam logic [1:0]  HZ_WB = 2'b01;
  localparam logic [31:0] STALL_WB = 32'd4;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic iss(input logic v, input logic s0e, input logic [3:0] s0, input logic s1e, input logic [3:0] s1,
                     input logic d0e, input logic [3:0] d0, input logic d1e, input logic [3:0] d1);
    sb.iss_valid = v; sb.iss_src0_en = s0e; sb.iss_src0 = s0; sb.iss_src1_en = s1e; sb.iss_src1 = s1;
    sb.iss_dst0_en = d0e; sb.iss_dst0 = d0; sb.iss_dst1_en = d1e; sb.iss_dst1 = d1;
  endtask
  task automatic wb(input logic v, input logic d0e, input logic [3:0] d0, input logic d1e, input logic [3:0] d1);
    sb.wb_valid = v; sb.wb_dst0_en = d0e; sb.wb_dst0 = d0; sb.wb_dst1_en = d1e; sb.wb_dst1 = d1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset_n = 1'b0; flush = 1'b0;
    iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0, 0, 0);
    #1;
    check("rst_busy", 32'(busy_vec), 32'h0);
    check("rst_uflow", 32'(underflow_err), 32'h0);
    check("rst_stall", stall_cycles, 32'h0);
    check("rst_hazard", 32'(sb.hazard), 32'h0);
    check("rst_ready", 32'(sb.iss_ready), 32'h1);
    tick; tick;
    reset_n = 1'b1;
    iss(1, 1, 3, 0, 0, 1, 5, 0, 0);
    #1 check("first_ready", 32'(sb.iss_ready), 32'h1);
    tick;
    iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("first_busy", 32'(busy_vec), 32'h0020);
    check("first_hazard", 32'(sb.hazard), 32'h0);
    check("first_stall", stall_cycles, 32'h0);
    iss(1, 1, 5, 0, 0, 0, 0, 0, 0);
    #1;
    check("raw_hazard", 32'(sb.hazard), 32'h1);
    check("raw_ready", 32'(sb.iss_ready), 32'h0);
    tick; tick; tick;
    check("raw_stall3", stall_cycles, 32'd3);
    wb(1, 1, 5, 0, 0);
    #1 check("raw_wb_hazard", 32'(sb.hazard), 32'(HZ_WB));
    tick;
    iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0, 0, 0);
    #1;
    check("raw_stall_end", stall_cycles, STALL_WB);
    check("raw_busy_clear", 32'(busy_vec), 32'h0);
    iss(1, 0, 0, 0, 0, 1, 4, 1, 4);
    #1 check("push_ready", 32'(sb.iss_ready), 32'h1);
    tick;
    iss(0, 0, 0, 0, 0, 1, 4, 1, 4);
    #1;
    check("push_sat_ready", 32'(sb.iss_ready), 32'h0);
    check("push_busy", 32'(busy_vec), 32'h0010);
    wb(1, 1, 4, 1, 4);
    tick;
    wb(0, 0, 0, 0, 0);
    #1;
    check("pop_busy", 32'(busy_vec), 32'h0);
    check("pop_ready", 32'(sb.iss_ready), 32'h1);
    sb.iss_valid = 1'b1;
    tick;
    sb.iss_valid = 1'b0;
    #1 check("push2_busy", 32'(busy_vec), 32'h0010);
    wb(1, 1, 4, 1, 4);
    tick;
    wb(0, 0, 0, 0, 0);
    #1;
    check("pop2_busy", 32'(busy_vec), 32'h0);
    check("push_stall_hold", stall_cycles, STALL_WB);
    iss(1, 0, 0, 0, 0, 1, 7, 0, 0);
    tick;
    wb(1, 1, 7, 0, 0);
    #1 check("same_ready", 32'(sb.iss_ready), 32'h1);
    tick;
    iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0, 0, 0);
    #1 check("same_busy", 32'(busy_vec), 32'h0080);
    wb(1, 1, 7, 0, 0);
    tick;
    wb(0, 0, 0, 0, 0);
    #1;
    check("same_release", 32'(busy_vec), 32'h0);
    check("no_uflow", 32'(underflow_err), 32'h0);
    wb(1, 1, 9, 0, 0);
    tick;
    wb(0, 0, 0, 0, 0);
    #1;
    check("uflow_set", 32'(underflow_err), 32'h1);
    check("uflow_busy", 32'(busy_vec), 32'h0);
    repeat (10) tick;
    check("uflow_sticky", 32'(underflow_err), 32'h1);
    reset_n = 1'b0;
    #1;
    check("uflow_rst", 32'(underflow_err), 32'h0);
    check("stall_rst", stall_cycles, 32'h0);
    tick;
    reset_n = 1'b1;
    iss(1, 0, 0, 0, 0, 1, 2, 1, 4);
    tick;
    iss(1, 0, 0, 0, 0, 1, 11, 0, 0);
    tick;
    iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("pre_flush_busy", 32'(busy_vec), 32'h0814);
    iss(1, 0, 0, 0, 0, 1, 6, 0, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("flush_busy", 32'(busy_vec), 32'h0);
    iss(1, 0, 0, 0, 0, 1, 15, 0, 0);
    tick;
    iss(1, 0, 0, 1, 15, 0, 0, 0, 0);
    #1;
    check("src1_hazard", 32'(sb.hazard), 32'h2);
    check("src1_ready", 32'(sb.iss_ready), 32'h0);
    tick; tick;
    check("mid_stall", stall_cycles, 32'd2);
    check("mid_busy", 32'(busy_vec), 32'h8000);
    reset_n = 1'b0;
    #1;
    check("mid_rst_stall", stall_cycles, 32'h0);
    check("mid_rst_busy", 32'(busy_vec), 32'h0);
    check("mid_rst_ready", 32'(sb.iss_ready), 32'h1);
    tick;
    reset_n = 1'b1;
    iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
